sisc_ctrl_fsm: RTL and testbench
================================

Name: sisc_ctrl_fsm

Overview:
- Second-generation SISC control unit: a multi-cycle Moore FSM that sequences fetch, decode, execute, mem and writeback.
- Generates register-file, ALU, PC, IR and data-memory control for the full SISC opcode set: ALU, load, store and the four conditional branches.
- Adds memory ready handshakes with a timeout, a hardware halt/fault state in place of a simulator stop, and a retired-instruction counter.
- Sits between the IR/status register and the datapath.

Parameters:
- STATW, 4: width of stat and mm; branch condition mask width.
- MEM_TIMEOUT, 15: maximum wait cycles for a ready in FETCH or MEM; 0 disables the timeout (wait forever).
- FETCH_WAIT, 1: 1 = FETCH waits for im_rdy; 0 = im_rdy is ignored and treated as 1.
- CNTW, 16: width of instr_cnt.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- opcode  in  4  IR[31:28]
- mm  in  STATW  IR mode/condition mask field
- stat  in  STATW  condition-code register
- im_rdy  in  1  instruction memory ready
- dm_rdy  in  1  data memory ready
- rf_we  out  1  register file write enable
- wb_sel  out  1  0 = ALU result, 1 = memory data
- alu_op  out  2  ALU control
- stat_en  out  1  condition-code update enable
- ir_load  out  1  IR load strobe
- pc_write  out  1  PC write enable
- pc_sel  out  2  0 = PC+1, 1 = absolute target, 2 = PC-relative target
- im_req  out  1  instruction fetch request
- dm_req  out  1  data memory request
- dm_we  out  1  data memory write
- halted  out  1  sticky; FSM is in HALT
- fault  out  1  sticky; memory timeout occurred
- instr_cnt  out  CNTW  retired-instruction count

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named rst.
- Reset (rst=1 at posedge) forces state START, halted=0, fault=0, instr_cnt=0 and the wait counter to 0. rst overrides every other event, including mid-wait and HALT.
- Opcodes: NOOP=0, LOD=1, STR=2, SWP=3 (reserved, executes as NOOP), BRA=4, BRR=5, BNE=6, BNR=7, ALU=8, HLT=15. Other codes execute as NOOP.
- States: START, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT.
- START -> FETCH.
- FETCH:
  - im_req=1 throughout.
  - When im_rdy=1 (or FETCH_WAIT=0): ir_load=1, pc_write=1, pc_sel=0, then -> DECODE.
  - Otherwise stay and increment the wait counter.
- DECODE:
  - opcode=HLT -> HALT.
  - Else -> EXECUTE.
- EXECUTE:
  - ALU: alu_op=00 if mm==0, 01 if mm==8; stat_en=1.
  - LOD/STR: alu_op=01 (address = base + immediate).
  - Branch taken:
    - BRA/BRR are taken when (stat & mm) != 0.
    - BNE/BNR are taken when (stat & mm) == 0.
    - On a taken branch: pc_write=1, pc_sel=1 for BRA/BNE, 2 for BRR/BNR.
  - Not-taken branch: no PC write.
  - Always -> MEM.
- MEM:
  - ALU: alu_op=10 if mm==0, 11 if mm==8.
  - LOD: dm_req=1, alu_op=01; wait for dm_rdy.
  - STR: dm_req=1, dm_we=1, alu_op=01; wait for dm_rdy.
  - Other opcodes leave MEM unconditionally after 1 cycle.
  - On dm_rdy=1 (or a non-memory opcode) -> WRITEBACK.
- WRITEBACK:
  - ALU: rf_we=1, wb_sel=0, alu_op per MEM rule.
  - LOD: rf_we=1, wb_sel=1.
  - Always -> FETCH; instr_cnt increments on this transition.
  - instr_cnt wraps modulo 2^CNTW; HLT is not counted.
- Wait counter:
  - Clears on entry to FETCH or MEM.
  - Increments each cycle a ready signal is low.
  - When the counter reaches MEM_TIMEOUT with ready still low (MEM_TIMEOUT != 0): fault<=1 -> HALT.
  - A ready arriving on that same cycle wins: no fault, normal transition.
- HALT: absorbing. All strobes are 0, halted=1, alu_op=10; only rst exits.
- Defaults in every state not listed above: rf_we=0, wb_sel=0, alu_op=10, all strobes 0.
- All strobes are combinational from state and inputs. halted, fault and instr_cnt are registered.
- Inputs are sampled at posedge only; opcode/mm must be stable from DECODE to WRITEBACK.

Test Plan:
- rst=1 for 2 cycles, then 0 -> START, then FETCH on the next cycle. All outputs 0 during reset; alu_op=10; instr_cnt=0.
- ALU add (opcode=8, mm=0), im_rdy=1, dm_rdy=1 -> 5 cycles FETCH..WRITEBACK.
  - alu_op is 00 in EXECUTE, 10 in MEM, 10 in WRITEBACK.
  - rf_we=1 only in WRITEBACK; stat_en=1 only in EXECUTE; instr_cnt=1 afterwards.
- ALU immediate (opcode=8, mm=8) -> alu_op 01 in EXECUTE, 11 in MEM.
- LOD with dm_rdy low for 3 cycles -> MEM held 4 cycles with dm_req=1, then WRITEBACK with rf_we=1 and wb_sel=1.
- Branch cases:
  - BRR, stat=0100, mm=0100 -> pc_write=1, pc_sel=2 in EXECUTE.
  - BNE, stat=0100, mm=0100 -> no pc_write in EXECUTE.
  - BNE, stat=0000, mm=0001 -> pc_sel=1 with pc_write=1.
- Timeout and halt:
  - MEM_TIMEOUT=15, STR with dm_rdy held 0 -> after 15 wait cycles fault=1, halted=1, state stays HALT.
  - rst=1 then clears both flags.
  - A separate HLT instruction -> halted=1, fault=0, instr_cnt unchanged.

Source files
------------

// File: rtl/sisc_ctrl_fsm.sv
// SISC multi-cycle control unit: sequences fetch/decode/execute/mem/writeback,
// handles memory ready handshakes with a timeout, and provides halt/fault/retire status.
module sisc_ctrl_fsm #(
  parameter int STATW       = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter bit FETCH_WAIT  = 1'b1,
  parameter int CNTW        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       opcode,
  input  logic [STATW-1:0] mm,
  input  logic [STATW-1:0] stat,
  input  logic             im_rdy,
  input  logic             dm_rdy,
  output logic             rf_we,
  output logic             wb_sel,
  output logic [1:0]       alu_op,
  output logic             stat_en,
  output logic             ir_load,
  output logic             pc_write,
  output logic [1:0]       pc_sel,
  output logic             im_req,
  output logic             dm_req,
  output logic             dm_we,
  output logic             halted,
  output logic             fault,
  output logic [CNTW-1:0]  instr_cnt
);

  localparam int WAITW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  localparam logic [3:0] OP_LOD = 4'd1;
  localparam logic [3:0] OP_STR = 4'd2;
  localparam logic [3:0] OP_ALU = 4'd8;
  localparam logic [3:0] OP_HLT = 4'd15;

  typedef enum logic [2:0] {
    START, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT
  } state_t;

  state_t           state_reg;
  logic [WAITW-1:0] wait_cnt_reg;

  logic is_alu, is_lod, is_str, is_mem, is_br;
  logic br_rel, br_neg, cond_hit, br_taken, mm_imm;
  logic fetch_ok, timeout_hit;

  assign is_alu   = (opcode == OP_ALU);
  assign is_lod   = (opcode == OP_LOD);
  assign is_str   = (opcode == OP_STR);
  assign is_mem   = is_lod || is_str;
  // Branches occupy 4..7: bit0 selects PC-relative, bit1 inverts the condition.
  assign is_br    = (opcode[3:2] == 2'b01);
  assign br_rel   = opcode[0];
  assign br_neg   = opcode[1];
  assign cond_hit = ((stat & mm) != '0);
  assign br_taken = is_br && (br_neg ? !cond_hit : cond_hit);
  assign mm_imm   = (mm == STATW'(4'd8));

  assign fetch_ok    = im_rdy || !FETCH_WAIT;
  // Fires on the wait cycle that would bring the counter up to MEM_TIMEOUT.
  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt_reg == WAITW'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= START;
      wait_cnt_reg <= '0;
      halted       <= 1'b0;
      fault        <= 1'b0;
      instr_cnt    <= '0;
    end else begin
      case (state_reg)
        START: begin
          state_reg    <= FETCH;
          wait_cnt_reg <= '0;
        end
        FETCH: begin
          if (fetch_ok) begin
            state_reg <= DECODE;
          end else if (timeout_hit) begin
            fault     <= 1'b1;
            halted    <= 1'b1;
            state_reg <= HALT;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + WAITW'(1);
          end
        end
        DECODE: begin
          if (opcode == OP_HLT) begin
            halted    <= 1'b1;
            state_reg <= HALT;
          end else begin
            state_reg <= EXECUTE;
          end
        end
        EXECUTE: begin
          state_reg    <= MEM;
          wait_cnt_reg <= '0;
        end
        MEM: begin
          if (!is_mem || dm_rdy) begin
            state_reg <= WRITEBACK;
          end else if (timeout_hit) begin
            fault     <= 1'b1;
            halted    <= 1'b1;
            state_reg <= HALT;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + WAITW'(1);
          end
        end
        WRITEBACK: begin
          state_reg    <= FETCH;
          wait_cnt_reg <= '0;
          instr_cnt    <= instr_cnt + CNTW'(1);
        end
        HALT: state_reg <= HALT;
        default: state_reg <= START;
      endcase
    end
  end

  always_comb begin
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    alu_op   = 2'b10;
    stat_en  = 1'b0;
    ir_load  = 1'b0;
    pc_write = 1'b0;
    pc_sel   = 2'b00;
    im_req   = 1'b0;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    case (state_reg)
      FETCH: begin
        im_req = 1'b1;
        if (fetch_ok) begin
          ir_load  = 1'b1;
          pc_write = 1'b1;
        end
      end
      EXECUTE: begin
        if (is_alu) begin
          alu_op  = mm_imm ? 2'b01 : 2'b00;
          stat_en = 1'b1;
        end else if (is_mem) begin
          alu_op = 2'b01;
        end else if (br_taken) begin
          pc_write = 1'b1;
          pc_sel   = br_rel ? 2'b10 : 2'b01;
        end
      end
      MEM: begin
        if (is_alu) begin
          alu_op = mm_imm ? 2'b11 : 2'b10;
        end else if (is_mem) begin
          alu_op = 2'b01;
          dm_req = 1'b1;
          dm_we  = is_str;
        end
      end
      WRITEBACK: begin
        if (is_alu) begin
          rf_we  = 1'b1;
          alu_op = mm_imm ? 2'b11 : 2'b10;
        end else if (is_lod) begin
          rf_we  = 1'b1;
          wb_sel = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sisc_ctrl_fsm.sv
// Self-checking bench for sisc_ctrl_fsm: directed vector table, hand sequences for
// reset/timeout/halt, and random instructions checked against an instruction-level model.
module tb_sisc_ctrl_fsm;
  localparam int STATW = 4;
  localparam int MEM_TIMEOUT = 15;
  localparam int CNTW = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       opcode;
  logic [STATW-1:0] mm, stat;
  logic             im_rdy, dm_rdy;
  logic             rf_we, wb_sel, stat_en, ir_load, pc_write, im_req, dm_req, dm_we;
  logic [1:0]       alu_op, pc_sel;
  logic             halted, fault;
  logic [CNTW-1:0]  instr_cnt;

  sisc_ctrl_fsm #(.STATW(STATW), .MEM_TIMEOUT(MEM_TIMEOUT), .FETCH_WAIT(1'b1), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mm(mm), .stat(stat),
    .im_rdy(im_rdy), .dm_rdy(dm_rdy), .rf_we(rf_we), .wb_sel(wb_sel), .alu_op(alu_op),
    .stat_en(stat_en), .ir_load(ir_load), .pc_write(pc_write), .pc_sel(pc_sel),
    .im_req(im_req), .dm_req(dm_req), .dm_we(dm_we), .halted(halted), .fault(fault),
    .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  // Per-instruction observation summary.
  typedef struct {
    int cycles; int ir_loads; int pc_writes; int br_sel; int rf_wes; int wb_mem;
    int stat_ens; int dm_reqs; int dm_wes; int alu00; int alu01; int alu11;
    int faulted; int cnt_delta;
  } meas_t;

  typedef struct {
    logic [3:0] op; logic [3:0] m; logic [3:0] s; int f; int d; meas_t exp;
  } vec_t;

  int n_checks = 0;
  int n_fail = 0;
  int exp_cnt = 0;
  logic [1:0] trace_alu [64];
  logic       trace_rf  [64];
  logic       trace_st  [64];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int strobes();
    return int'({rf_we, wb_sel, stat_en, ir_load, pc_write, pc_sel, im_req, dm_req, dm_we});
  endfunction

  // Instruction-level reference: cost and strobe totals derived from the opcode rules.
  function automatic meas_t model(input logic [3:0] op, input logic [3:0] m,
                                  input logic [3:0] s, input int f, input int d);
    meas_t r;
    bit alu, lod, str, memop, br, any, taken;
    int sel;
    r = '{default: 0};
    alu = (op == 8); lod = (op == 1); str = (op == 2); memop = lod || str;
    br = (op >= 4 && op <= 7);
    any = ((s & m) != 0);
    taken = br && (((op == 4) || (op == 5)) ? any : !any);
    sel = ((op == 5) || (op == 7)) ? 2 : 1;
    r.cycles    = (f + 1) + 1 + 1 + (memop ? d + 1 : 1) + 1;
    r.ir_loads  = 1;
    r.pc_writes = 1 + int'(taken);
    r.br_sel    = taken ? sel : 0;
    r.rf_wes    = int'(alu || lod);
    r.wb_mem    = int'(lod);
    r.stat_ens  = int'(alu);
    r.dm_reqs   = memop ? d + 1 : 0;
    r.dm_wes    = str ? d + 1 : 0;
    r.alu00     = int'(alu && m == 0);
    r.alu01     = int'(alu && m == 8) + (memop ? d + 2 : 0);
    r.alu11     = (alu && m == 8) ? 2 : 0;
    r.cnt_delta = 1;
    return r;
  endfunction

  // Starts in FETCH (just after a posedge); returns once the retire count moves.
  task automatic run_instr(input logic [3:0] op, input logic [3:0] m, input logic [3:0] s,
                           input int f, input int d, output meas_t r);
    int fw, mw;
    bit done;
    logic [CNTW-1:0] c0;
    r = '{default: 0};
    fw = 0; mw = 0; done = 0; c0 = instr_cnt;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      @(negedge clk);
      opcode = op; mm = m; stat = s;
      im_rdy = (fw >= f);
      dm_rdy = (mw >= d);
      #1;
      trace_alu[cyc] = alu_op; trace_rf[cyc] = rf_we; trace_st[cyc] = stat_en;
      r.cycles++;
      if (im_req && !im_rdy) fw++;
      if (ir_load) r.ir_loads++;
      if (pc_write) begin
        r.pc_writes++;
        if (!ir_load) r.br_sel = int'(pc_sel);
      end
      if (rf_we) begin
        r.rf_wes++;
        if (wb_sel) r.wb_mem++;
      end
      if (stat_en) r.stat_ens++;
      if (dm_req) begin
        r.dm_reqs++;
        if (!dm_rdy) mw++;
      end
      if (dm_we) r.dm_wes++;
      if (alu_op == 2'b00) r.alu00++;
      if (alu_op == 2'b01) r.alu01++;
      if (alu_op == 2'b11) r.alu11++;
      @(posedge clk);
      #1;
      if (instr_cnt != c0) done = 1;
    end
    check($sformatf("retire_within_budget op=%0d", op), int'(done), 1);
    r.faulted = int'(fault);
    r.cnt_delta = int'(instr_cnt - c0);
    if (done) exp_cnt++;
  endtask

  task automatic cmp_meas(input string tag, input meas_t a, input meas_t e);
    check({tag, ".cycles"}, a.cycles, e.cycles);
    check({tag, ".ir_load"}, a.ir_loads, e.ir_loads);
    check({tag, ".pc_write"}, a.pc_writes, e.pc_writes);
    check({tag, ".br_pc_sel"}, a.br_sel, e.br_sel);
    check({tag, ".rf_we"}, a.rf_wes, e.rf_wes);
    check({tag, ".wb_sel_mem"}, a.wb_mem, e.wb_mem);
    check({tag, ".stat_en"}, a.stat_ens, e.stat_ens);
    check({tag, ".dm_req"}, a.dm_reqs, e.dm_reqs);
    check({tag, ".dm_we"}, a.dm_wes, e.dm_wes);
    check({tag, ".alu00"}, a.alu00, e.alu00);
    check({tag, ".alu01"}, a.alu01, e.alu01);
    check({tag, ".alu11"}, a.alu11, e.alu11);
    check({tag, ".fault"}, a.faulted, e.faulted);
    check({tag, ".cnt_delta"}, a.cnt_delta, e.cnt_delta);
  endtask

  // Leaves the DUT in its first FETCH cycle, just after the posedge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; im_rdy = 1'b0; dm_rdy = 1'b0; opcode = 4'd0; mm = '0; stat = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_strobes", strobes(), 0);
    check("rst_alu_op", int'(alu_op), 2);
    check("rst_halted", int'(halted), 0);
    check("rst_fault", int'(fault), 0);
    check("rst_instr_cnt", int'(instr_cnt), 0);
    rst = 1'b0;
    #1;
    check("start_im_req", int'(im_req), 0);
    @(posedge clk);
    #1;
    check("fetch_im_req", int'(im_req), 1);
    exp_cnt = 0;
  endtask

  vec_t  vecs [13];
  meas_t act, exp;

  initial begin
    vecs[0]  = '{4'd8,  4'd0, 4'd0, 0, 0,  '{5, 1,1,0,1,0,1,0,0,1,0,0,0,1}};  // ALU reg
    vecs[1]  = '{4'd8,  4'd8, 4'd0, 1, 0,  '{6, 1,1,0,1,0,1,0,0,0,1,2,0,1}};  // ALU imm
    vecs[2]  = '{4'd1,  4'd3, 4'd0, 0, 3,  '{8, 1,1,0,1,1,0,4,0,0,5,0,0,1}};  // LOD wait 3
    vecs[3]  = '{4'd5,  4'd4, 4'd4, 0, 0,  '{5, 1,2,2,0,0,0,0,0,0,0,0,0,1}};  // BRR taken
    vecs[4]  = '{4'd6,  4'd4, 4'd4, 0, 0,  '{5, 1,1,0,0,0,0,0,0,0,0,0,0,1}};  // BNE not taken
    vecs[5]  = '{4'd6,  4'd1, 4'd0, 0, 0,  '{5, 1,2,1,0,0,0,0,0,0,0,0,0,1}};  // BNE taken
    vecs[6]  = '{4'd2,  4'd0, 4'd0, 2, 14, '{21,1,1,0,0,0,0,15,15,0,16,0,0,1}}; // STR ready on last cycle
    vecs[7]  = '{4'd0,  4'd0, 4'd0, 14, 0, '{19,1,1,0,0,0,0,0,0,0,0,0,0,1}};  // fetch ready on last cycle
    vecs[8]  = '{4'd3,  4'd5, 4'd5, 0, 0,  '{5, 1,1,0,0,0,0,0,0,0,0,0,0,1}};  // SWP as NOOP
    vecs[9]  = '{4'd4,  4'd8, 4'd3, 0, 0,  '{5, 1,1,0,0,0,0,0,0,0,0,0,0,1}};  // BRA not taken
    vecs[10] = '{4'd7,  4'hD, 4'd2, 0, 0,  '{5, 1,2,2,0,0,0,0,0,0,0,0,0,1}};  // BNR taken
    vecs[11] = '{4'd12, 4'd0, 4'd0, 0, 2,  '{5, 1,1,0,0,0,0,0,0,0,0,0,0,1}};  // undefined op
    vecs[12] = '{4'd4,  4'd2, 4'hA, 1, 0,  '{6, 1,2,1,0,0,0,0,0,0,0,0,0,1}};  // BRA taken

    do_reset();

    // Cycle-by-cycle ALU add: FETCH, DECODE, EXECUTE, MEM, WRITEBACK.
    run_instr(4'd8, 4'd0, 4'd0, 0, 0, act);
    check("add_cycles", act.cycles, 5);
    check("add_alu_exec", int'(trace_alu[2]), 0);
    check("add_alu_mem", int'(trace_alu[3]), 2);
    check("add_alu_wb", int'(trace_alu[4]), 2);
    check("add_stat_en_exec", int'(trace_st[2]), 1);
    check("add_rf_we_wb", int'(trace_rf[4]), 1);
    check("add_rf_we_total", act.rf_wes, 1);
    check("add_instr_cnt", int'(instr_cnt), 1);

    foreach (vecs[i]) begin
      run_instr(vecs[i].op, vecs[i].m, vecs[i].s, vecs[i].f, vecs[i].d, act);
      cmp_meas($sformatf("vec%0d", i), act, vecs[i].exp);
      $display("vec %0d op=%0d mm=%0h stat=%0h cycles=%0d", i, vecs[i].op, vecs[i].m,
               vecs[i].s, act.cycles);
    end

    for (int n = 0; n < 60; n++) begin
      logic [3:0] op, m, s;
      int f, d;
      op = 4'($urandom_range(0, 14));
      m  = (op == 4'd8) ? (($urandom_range(0, 1) == 1) ? 4'd8 : 4'd0) : 4'($urandom_range(0, 15));
      s  = 4'($urandom_range(0, 15));
      f  = $urandom_range(0, 3);
      d  = $urandom_range(0, 5);
      exp = model(op, m, s, f, d);
      run_instr(op, m, s, f, d, act);
      cmp_meas($sformatf("rnd%0d", n), act, exp);
      $display("rnd %0d op=%0d mm=%0h stat=%0h f=%0d d=%0d cycles=%0d", n, op, m, s, f, d,
               act.cycles);
    end
    check("instr_cnt_total", int'(instr_cnt), exp_cnt);

    // STR with dm_rdy never arriving: MEM_TIMEOUT wait cycles, then fault into HALT.
    begin
      int mc;
      mc = 0;
      for (int cyc = 0; cyc < 40 && !halted; cyc++) begin
        @(negedge clk);
        opcode = 4'd2; mm = '0; stat = '0; im_rdy = 1'b1; dm_rdy = 1'b0;
        #1;
        if (dm_req) mc++;
        @(posedge clk);
        #1;
      end
      check("timeout_mem_cycles", mc, MEM_TIMEOUT);
      check("timeout_fault", int'(fault), 1);
      check("timeout_halted", int'(halted), 1);
      for (int cyc = 0; cyc < 4; cyc++) begin
        @(negedge clk);
        im_rdy = 1'b1; dm_rdy = 1'b1;
        #1;
        check("halt_strobes", strobes(), 0);
        check("halt_alu_op", int'(alu_op), 2);
        check("halt_sticky", int'(halted), 1);
      end
      check("timeout_instr_cnt", int'(instr_cnt), exp_cnt);
      $display("timeout mem_cycles=%0d fault=%0d halted=%0d", mc, fault, halted);
    end

    do_reset();

    // HLT retires nothing and halts without a fault.
    begin
      int hc;
      hc = 0;
      for (int cyc = 0; cyc < 10 && !halted; cyc++) begin
        @(negedge clk);
        opcode = 4'd15; mm = '0; stat = '0; im_rdy = 1'b1; dm_rdy = 1'b1;
        #1;
        hc++;
        @(posedge clk);
        #1;
      end
      check("hlt_cycles", hc, 2);
      check("hlt_halted", int'(halted), 1);
      check("hlt_fault", int'(fault), 0);
      check("hlt_instr_cnt", int'(instr_cnt), 0);
      $display("hlt cycles=%0d halted=%0d fault=%0d", hc, halted, fault);
    end

    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
